// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: state encoding, nibble width
// and the width of the nibble index counter.
package nibble_serial_adder_pkg;

  localparam int NIB  = 4;
  localparam int IDXW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the nibble-serial adder.
// The sub signal only exists when NIBBLE_SERIAL_ADDER_SUBTRACT_EN is defined.
interface nibble_serial_adder_if #(parameter int WORDS = 4);

  localparam int W = 4 * WORDS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/nibble_serial_adder_rca.sv
// Existing 4-bit ripple-carry adder block, reused once per nibble by
// nibble_serial_adder.
module ripple_carry_4_bit_adder (
  output logic [3:0] S,
  output logic       C4,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C0
);

  // Carry ripples through a block-local variable to keep the chain acyclic.
  always_comb begin
    logic c;
    S = '0;
    c = C0;
    for (int i = 0; i < 4; i++) begin
      S[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    C4 = c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W=4*WORDS bit adder: one shared 4-bit adder, LSB nibble first.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_ADDER_SUBTRACT_EN.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  nibble_serial_adder_if.slave  bus
);

  localparam int W = NIB * WORDS;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_aQ;
  logic [W-1:0]    r_bQ;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_carry;
  logic [IDXW-1:0] r_idx;

  logic            w_accept;
  logic            w_last;
  logic            w_busy;
  logic            w_done;
  logic [W-1:0]    w_bIn;
  logic            w_cIn;
  logic [NIB-1:0]  w_aNib;
  logic [NIB-1:0]  w_bNib;
  logic [NIB-1:0]  w_s;
  logic            w_c4;

`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  // Subtraction as a + ~b + 1: invert b at latch time and force the first carry.
  assign w_bIn = bus.sub ? ~bus.b : bus.b;
  assign w_cIn = bus.sub | bus.cin;
`else
  assign w_bIn = bus.b;
  assign w_cIn = bus.cin;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_aNib = r_aQ[r_idx*NIB +: NIB];
  assign w_bNib = r_bQ[r_idx*NIB +: NIB];

  ripple_carry_4_bit_adder u_rca (
    .S  (w_s),
    .C4 (w_c4),
    .A  (w_aNib),
    .B  (w_bNib),
    .C0 (r_carry)
  );

  // Result nibbles are written in place; the top carry goes only to cout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aQ    <= '0;
      r_bQ    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_aQ    <= bus.a;
      r_bQ    <= w_bIn;
      r_carry <= w_cIn;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*NIB +: NIB] <= w_s;
      r_carry <= w_c4;
      r_idx   <= r_idx + 1'b1;
      if (w_last) r_cout <= w_c4;
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with WORDS=4; subtract
// vectors run only when NIBBLE_SERIAL_ADDER_SUBTRACT_EN is defined.
module tb_nibble_serial_adder;

  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   doneCount = 0;
  int   lastDone = 0;
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
  logic subReq = 1'b0;
`endif

  nibble_serial_adder_if #(.WORDS(WORDS)) bus ();

  nibble_serial_adder #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) if (bus.done === 1'b1) doneCount <= doneCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
    bus.sub   = subReq;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, WORDS RUN edges, DONE cycle, back to IDLE.
  task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] expSum, input logic expCout,
                       input bit checkGap);
    applyStimulus(a, b, c);
    tick();
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.cin   = ~c;
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
    repeat (WORDS - 1) tick();
    checkOutput({tag, "_early"}, 32'(bus.done), 32'd0);
    tick();
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(expSum));
    checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(expCout));
    checkOutput({tag, "_idle"}, 32'(bus.busy), 32'd0);
    if (checkGap) checkOutput({tag, "_gap"}, 32'(cycle - lastDone), 32'(WORDS + 2));
    lastDone = cycle;
    tick();
    checkOutput({tag, "_fall"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int d0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
    bus.sub   = 1'b0;
`endif
    #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_sum", 32'(bus.sum), 32'd0);
    checkOutput("rst_cout", 32'(bus.cout), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    runOp("carry8", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    runOp("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    runOp("cinOnly", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b1);

    // Start held high through RUN and DONE must not launch another operation.
    d0 = doneCount;
    applyStimulus(16'h1111, 16'h1111, 1'b0);
    tick();
    bus.a   = 16'hFFFF;
    bus.b   = 16'hFFFF;
    bus.cin = 1'b1;
    repeat (WORDS) tick();
    checkOutput("ign_done", 32'(bus.done), 32'd1);
    checkOutput("ign_sum", 32'(bus.sum), 32'h2222);
    checkOutput("ign_cout", 32'(bus.cout), 32'd0);
    tick();
    bus.start = 1'b0;
    checkOutput("ign_noRestart", 32'(bus.busy), 32'd0);
    tick();
    checkOutput("ign_stillIdle", 32'(bus.busy), 32'd0);
    checkOutput("ign_pulses", 32'(doneCount - d0), 32'd1);

    // Reset in the second RUN cycle aborts without a done pulse.
    d0 = doneCount;
    applyStimulus(16'hABCD, 16'h1234, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_sum", 32'(bus.sum), 32'd0);
    checkOutput("abort_cout", 32'(bus.cout), 32'd0);
    #2;
    reset = 1'b0;
    tick();
    checkOutput("abort_noPulse", 32'(doneCount - d0), 32'd0);
    runOp("afterAbort", 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 2; c++) begin
        runOp("walk", 16'(i), 16'h0003, 1'(c), 16'(i + 3 + c), 1'b0, !(i == 0 && c == 0));
      end
    end

`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
    subReq = 1'b1;
    runOp("subPos", 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b1, 1'b0);
    runOp("subNeg", 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    subReq = 1'b0;
    runOp("subOff", 16'h1234, 16'h0235, 1'b1, 16'h146A, 1'b0, 1'b1);
`endif

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
